// File: rtl/sl_preceptron_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : sl_preceptron_pkg
//  Purpose  : Shared types, default sizing and helpers for the perceptron core.
//  Revision : 1.0  initial release
// =============================================================================
package sl_preceptron_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_N_INPUTS   = 16;
    localparam int DEF_W_BASE     = 0;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_LR_SHIFT   = 0;
    localparam int BIAS_ADDR      = DEF_W_BASE + DEF_N_INPUTS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_BIAS   = 3'd2,
        ST_SUM    = 3'd3,
        ST_UPD_RD = 3'd4,
        ST_UPD_WR = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // a +/- d clamped to the signed range of a width-bit word
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] d,
        input logic               sub,
        input int                 width
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = sub ? (a - d) : (a + d);
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic bit acc_width_ok(input int dw, input int n, input int aw);
        return aw >= (2 * dw + $clog2(n + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sl_preceptron_if.sv
`default_nettype none
// =============================================================================
//  Module   : sl_preceptron_if
//  Purpose  : Input-vector stream and single-port weight RAM bus of the core.
//  Revision : 1.0  initial release
// =============================================================================
interface sl_preceptron_if
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                         x_valid;
    logic signed [DATA_WIDTH-1:0] x_data;
    logic                         x_ready;
    logic                         mem_wen;
    logic                         mem_ren;
    logic        [ADDR_WIDTH-1:0] mem_addr;
    logic signed [DATA_WIDTH-1:0] mem_wdata;
    logic signed [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  x_valid, x_data, mem_rdata,
        output x_ready, mem_wen, mem_ren, mem_addr, mem_wdata
    );

    modport slave (
        output x_valid, x_data, mem_rdata,
        input  x_ready, mem_wen, mem_ren, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sl_preceptron_mac.sv
`default_nettype none
// =============================================================================
//  Module   : sl_preceptron_mac
//  Purpose  : Signed multiply, sign-extend and accumulate with clear/enable.
//  Revision : 1.0  initial release
// =============================================================================
module sl_preceptron_mac
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         clr,
    input  wire logic                         en,
    input  wire logic signed [DATA_WIDTH-1:0] a,
    input  wire logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]       acc
);
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    assign w_prod     = a * b;
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign acc        = r_acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sl_preceptron_core.sv
`default_nettype none
// =============================================================================
//  Module   : sl_preceptron_core
//  Purpose  : Perceptron evaluate/train engine driving a single-port weight RAM.
//  Revision : 1.0  initial release
// =============================================================================
module sl_preceptron_core
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int N_INPUTS   = DEF_N_INPUTS,
    parameter int W_BASE     = DEF_W_BASE,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LR_SHIFT   = DEF_LR_SHIFT
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   start,
    input  wire logic                   train,
    input  wire logic                   target,
    sl_preceptron_if.master             bus,
    output logic                        busy,
    output logic                        done,
    output logic                        y_out,
    output logic signed [ACC_WIDTH-1:0] acc_out,
    output logic                        updated
);
    localparam int                    IDX_W      = $clog2(N_INPUTS + 1);
    localparam logic [IDX_W-1:0]      c_last_x   = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0]      c_bias_idx = IDX_W'(N_INPUTS);
    localparam logic [ADDR_WIDTH-1:0] c_w_base   = ADDR_WIDTH'(W_BASE);
    localparam logic [ADDR_WIDTH-1:0] c_b_addr   = ADDR_WIDTH'(W_BASE + N_INPUTS);

    generate
        if (!acc_width_ok(DATA_WIDTH, N_INPUTS, ACC_WIDTH)) begin : g_bad_acc_width
            $error("ACC_WIDTH too small for DATA_WIDTH and N_INPUTS");
        end
        if (W_BASE + N_INPUTS >= (1 << ADDR_WIDTH)) begin : g_bad_addr_range
            $error("weight block does not fit in the RAM address space");
        end
    endgenerate

    state_t                       r_state;
    state_t                       w_next;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_train;
    logic                         r_target;
    logic                         r_pend;
    logic signed [DATA_WIDTH-1:0] r_x_last;
    logic signed [DATA_WIDTH-1:0] r_xbuf [0:N_INPUTS];
    logic                         r_y;
    logic signed [ACC_WIDTH-1:0]  r_acc_out;
    logic                         r_updated;

    logic                         w_accept;
    logic                         w_mac_clr;
    logic signed [ACC_WIDTH-1:0]  w_mac_acc;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic                         w_y;
    logic                         w_miss;
    logic signed [DATA_WIDTH-1:0] w_xsel;
    logic signed [DATA_WIDTH-1:0] w_xshift;
    logic signed [DATA_WIDTH-1:0] w_delta;
    logic signed [DATA_WIDTH-1:0] w_wdata;
    logic [ADDR_WIDTH-1:0]        w_idx_addr;

    assign w_accept   = (r_state == ST_FETCH) && bus.x_valid;
    assign w_mac_clr  = (r_state == ST_IDLE) && start;
    // In SUM the RAM returns the bias read issued from BIAS
    assign w_sum      = w_mac_acc + ACC_WIDTH'(bus.mem_rdata);
    assign w_y        = ~w_sum[ACC_WIDTH-1];
    assign w_miss     = r_train && (w_y != r_target);
    assign w_xsel     = r_xbuf[r_idx];
    assign w_xshift   = w_xsel >>> LR_SHIFT;
    assign w_delta    = (r_idx == c_bias_idx) ? DATA_WIDTH'(1) : w_xshift;
    assign w_wdata    = DATA_WIDTH'(sat_add(32'(bus.mem_rdata), 32'(w_delta), ~r_target, DATA_WIDTH));
    assign w_idx_addr = c_w_base + ADDR_WIDTH'(r_idx);

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign y_out   = r_y;
    assign acc_out = r_acc_out;
    assign updated = r_updated;

    sl_preceptron_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (w_mac_clr),
        .en  (r_pend),
        .a   (bus.mem_rdata),
        .b   (r_x_last),
        .acc (w_mac_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.x_ready   = 1'b0;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                bus.x_ready = 1'b1;
                if (bus.x_valid) begin
                    bus.mem_ren  = 1'b1;
                    bus.mem_addr = w_idx_addr;
                    if (r_idx == c_last_x) w_next = ST_BIAS;
                end
            end
            ST_BIAS: begin
                bus.mem_ren  = 1'b1;
                bus.mem_addr = c_b_addr;
                w_next       = ST_SUM;
            end
            ST_SUM: begin
                w_next = w_miss ? ST_UPD_RD : ST_DONE;
            end
            ST_UPD_RD: begin
                bus.mem_ren  = 1'b1;
                bus.mem_addr = w_idx_addr;
                w_next       = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = w_idx_addr;
                bus.mem_wdata = w_wdata;
                w_next        = (r_idx == c_bias_idx) ? ST_DONE : ST_UPD_RD;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_train   <= 1'b0;
            r_target  <= 1'b0;
            r_pend    <= 1'b0;
            r_x_last  <= '0;
            r_y       <= 1'b0;
            r_acc_out <= '0;
            r_updated <= 1'b0;
        end else begin
            // A product is accumulated the cycle after its weight read
            r_pend <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_train  <= train;
                        r_target <= target;
                        r_idx    <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.x_valid) begin
                        r_x_last <= bus.x_data;
                        r_idx    <= r_idx + IDX_W'(1);
                    end
                end
                ST_SUM: begin
                    r_acc_out <= w_sum;
                    r_y       <= w_y;
                    r_updated <= w_miss;
                    r_idx     <= '0;
                end
                ST_UPD_WR: begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xbuf[r_idx] <= bus.x_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sl_preceptron_core.sv
`default_nettype none
// =============================================================================
//  Module   : tb_sl_preceptron_core
//  Purpose  : Directed, table-driven self-checking bench for sl_preceptron_core.
//  Revision : 1.0  initial release
// =============================================================================
module tb_sl_preceptron_core;
    import sl_preceptron_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 6;
    localparam int N    = 16;
    localparam int ACCW = 24;

    logic clk = 1'b0;
    logic rst, start, train, target;
    logic busy, done, y_out, updated;
    logic signed [ACCW-1:0] acc_out;

    sl_preceptron_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sl_preceptron_core #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .N_INPUTS (N),
        .W_BASE (0), .ACC_WIDTH (ACCW), .LR_SHIFT (0)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .train (train), .target (target),
        .bus (bus), .busy (busy), .done (done), .y_out (y_out),
        .acc_out (acc_out), .updated (updated)
    );

    always #5 clk = ~clk;

    // Weight RAM model with a backdoor load port
    logic signed [DW-1:0] ram [0:63];
    logic                 ld_en;
    logic [AW-1:0]        ld_addr;
    logic signed [DW-1:0] ld_data;
    int wen_cnt  = 0;
    int ren_cnt  = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_ren ? ram[bus.mem_addr] : '0;
        if (bus.mem_wen) wen_cnt <= wen_cnt + 1;
        if (bus.mem_ren) ren_cnt <= ren_cnt + 1;
        if (bus.mem_wen && bus.mem_ren) both_cnt <= both_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int ren_bad;
    logic signed [DW-1:0] xv [0:N-1];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ram_wr(input int a, input int v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = DW'(v);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one operation; start sampled in cycle 0, cycles counted on negedges.
    // mode 0: x_valid always, 1: 1001 pattern, 2: random gaps
    task automatic run_op(input bit tr, input bit tg, input int mode, input int s1, input int s2,
                          output int dcyc, output int nd);
        int  k;
        int  cyc;
        bit  v;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0; dcyc = -1; nd = 0; ren_bad = 0; cyc = 0;
        @(negedge clk);
        train = tr; target = tg; start = 1'b1;
        bus.x_valid = 1'b0; bus.x_data = '0;
        forever begin
            if (cyc > 0) begin
                start = (cyc == s1) || (cyc == s2);
                if (k >= N)        v = 1'b0;
                else if (mode == 0) v = 1'b1;
                else if (mode == 1) v = pat[cyc % 4];
                else               v = 1'($urandom_range(0, 1));
                bus.x_valid = v;
                bus.x_data  = v ? xv[k] : '0;
            end
            #1;
            if (done) begin
                nd++;
                if (dcyc < 0) dcyc = cyc;
            end
            if (bus.x_ready && (bus.mem_ren !== bus.x_valid)) ren_bad++;
            if (bus.x_ready && bus.x_valid) k++;
            if (cyc >= 300 || (dcyc >= 0 && cyc >= dcyc + 6)) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; bus.x_valid = 1'b0;
    endtask

    typedef struct {
        bit load; bit tr; bit tg;
        int w; int b; int x;
        int e_acc; bit e_y; bit e_upd; int e_dcyc; int e_w; int e_b;
    } vec_t;

    vec_t vt [9];
    int   dcyc, nd, w0, r0, bad_w, hit;

    initial begin
        vt[0] = '{1, 0, 1,    1,  -40,    2,      -8, 0, 0, 19,  1,  -40};
        vt[1] = '{1, 1, 1,    1,  -40,    2,      -8, 0, 1, 53,  3,  -39};
        vt[2] = '{0, 1, 1,    0,    0,    2,      57, 1, 0, 19,  3,  -39};
        vt[3] = '{1, 1, 0,   -1,    5,    3,     -43, 0, 0, 19, -1,    5};
        vt[4] = '{1, 1, 1,    2,    0,   -1,     -32, 0, 1, 53,  1,    1};
        vt[5] = '{1, 1, 0,    5,   10,    4,     330, 1, 1, 53,  1,    9};
        vt[6] = '{1, 0, 0,    0,    0,    0,       0, 1, 0, 19,  0,    0};
        vt[7] = '{1, 0, 0, -128,  127, -128,  262271, 1, 0, 19, -128, 127};
        vt[8] = '{1, 1, 1,  127, -128, -128, -260224, 0, 1, 53, -1, -127};

        rst = 1'b1; start = 1'b0; train = 1'b0; target = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; bus.x_valid = 1'b0; bus.x_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst x_ready", bus.x_ready, 0);
        chk("rst mem_wen", bus.mem_wen, 0);
        chk("rst mem_ren", bus.mem_ren, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst acc_out", acc_out, 0);
        chk("rst y_out", y_out, 0);
        chk("rst updated", updated, 0);

        for (int v = 0; v < 9; v++) begin
            if (vt[v].load) begin
                for (int a = 0; a < N; a++) ram_wr(a, vt[v].w);
                ram_wr(BIAS_ADDR, vt[v].b);
            end
            for (int a = 0; a < N; a++) xv[a] = DW'(vt[v].x);
            w0 = wen_cnt; r0 = ren_cnt;
            run_op(vt[v].tr, vt[v].tg, 0, -1, -1, dcyc, nd);
            chk($sformatf("v%0d acc_out", v), acc_out, vt[v].e_acc);
            chk($sformatf("v%0d y_out", v), y_out, vt[v].e_y);
            chk($sformatf("v%0d updated", v), updated, vt[v].e_upd);
            chk($sformatf("v%0d done cycle", v), dcyc, vt[v].e_dcyc);
            chk($sformatf("v%0d done count", v), nd, 1);
            chk($sformatf("v%0d busy after", v), busy, 0);
            bad_w = 0;
            for (int a = 0; a < N; a++) if (ram[a] !== DW'(vt[v].e_w)) bad_w++;
            chk($sformatf("v%0d bad weights", v), bad_w, 0);
            chk($sformatf("v%0d bias", v), ram[BIAS_ADDR], vt[v].e_b);
            chk($sformatf("v%0d writes", v), wen_cnt - w0, vt[v].e_upd ? N + 1 : 0);
            chk($sformatf("v%0d reads", v), ren_cnt - r0, vt[v].e_upd ? 2 * (N + 1) : N + 1);
            chk($sformatf("v%0d ren vs beat", v), ren_bad, 0);
        end

        // Saturation high: w0 = 120 + 20 clamps to 127
        for (int a = 0; a < N; a++) begin ram_wr(a, 0); xv[a] = '0; end
        ram_wr(0, 120); ram_wr(1, 127); ram_wr(BIAS_ADDR, -128);
        xv[0] = 8'sd20; xv[1] = -8'sd30;
        run_op(1, 1, 0, -1, -1, dcyc, nd);
        chk("sat+ acc_out", acc_out, -1538);
        chk("sat+ updated", updated, 1);
        chk("sat+ w0", ram[0], 127);
        chk("sat+ w1", ram[1], 97);
        chk("sat+ w2", ram[2], 0);
        chk("sat+ bias", ram[BIAS_ADDR], -127);

        // Saturation low: w0 = -120 - 20 clamps to -128
        ram_wr(0, -120); ram_wr(1, 127); ram_wr(BIAS_ADDR, 0);
        xv[1] = 8'sd30;
        run_op(1, 0, 0, -1, -1, dcyc, nd);
        chk("sat- acc_out", acc_out, 1410);
        chk("sat- w0", ram[0], -128);
        chk("sat- w1", ram[1], 97);
        chk("sat- bias", ram[BIAS_ADDR], -1);

        // Varied vector: sum (i-8)(3i-20) + 7 = 1007, with and without gaps
        for (int a = 0; a < N; a++) begin ram_wr(a, a - 8); xv[a] = DW'(3 * a - 20); end
        ram_wr(BIAS_ADDR, 7);
        for (int m = 0; m < 3; m++) begin
            r0 = ren_cnt;
            run_op(0, 1, m, -1, -1, dcyc, nd);
            chk($sformatf("stall m%0d acc_out", m), acc_out, 1007);
            chk($sformatf("stall m%0d y_out", m), y_out, 1);
            chk($sformatf("stall m%0d ren vs beat", m), ren_bad, 0);
            chk($sformatf("stall m%0d reads", m), ren_cnt - r0, N + 1);
            chk($sformatf("stall m%0d done count", m), nd, 1);
        end

        // start pulsed during FETCH and during DONE must be ignored
        r0 = ren_cnt;
        run_op(0, 1, 0, 5, 19, dcyc, nd);
        chk("busy-start done cycle", dcyc, 19);
        chk("busy-start done count", nd, 1);
        chk("busy-start reads", ren_cnt - r0, N + 1);
        chk("busy-start idle", busy, 0);
        chk("busy-start acc_out", acc_out, 1007);

        // Reset during the write of w[5]
        for (int a = 0; a < N; a++) begin ram_wr(a, 1); xv[a] = 8'sd2; end
        ram_wr(BIAS_ADDR, -40);
        @(negedge clk);
        start = 1'b1; train = 1'b1; target = 1'b1; bus.x_valid = 1'b1; bus.x_data = 8'sd2;
        hit = 0;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (bus.mem_wen && bus.mem_addr == AW'(5)) begin
                rst = 1'b1; hit = 1;
            end
        end
        chk("rst-upd reached w5 write", hit, 1);
        @(negedge clk);
        rst = 1'b0; bus.x_valid = 1'b0;
        chk("rst-upd busy", busy, 0);
        chk("rst-upd done", done, 0);
        chk("rst-upd acc_out", acc_out, 0);
        chk("rst-upd updated", updated, 0);
        w0 = wen_cnt; r0 = ren_cnt;
        repeat (10) @(negedge clk);
        chk("rst-upd later writes", wen_cnt - w0, 0);
        chk("rst-upd later reads", ren_cnt - r0, 0);
        bad_w = 0;
        for (int a = 0; a < N; a++) if (ram[a] !== ((a <= 5) ? 8'sd3 : 8'sd1)) bad_w++;
        chk("rst-upd bad weights", bad_w, 0);
        chk("rst-upd bias", ram[BIAS_ADDR], -40);

        chk("wen and ren together", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sl_preceptron_core.md
Name: sl_preceptron_core

Overview:
Perceptron evaluate/train engine that sits directly downstream of the perceptron weight RAM and drives its single port.
- Streams an input vector in over a valid/ready handshake.
- Reads one weight per element, multiply-accumulates, adds the bias and applies a step activation.
- In train mode with a misclassification, performs read-modify-write updates of every weight and the bias in the RAM.

Parameters:
- DATA_WIDTH, 8: signed width of x, weights and bias; equals the RAM word width.
- ADDR_WIDTH, 6: RAM address width.
- N_INPUTS, 16: vector length. W_BASE+N_INPUTS must be < 2**ADDR_WIDTH.
- W_BASE, 0: address of w[0]. Weights occupy W_BASE..W_BASE+N_INPUTS-1; bias is at W_BASE+N_INPUTS.
- ACC_WIDTH, 24: signed accumulator width. Must be >= 2*DATA_WIDTH+clog2(N_INPUTS+1).
- LR_SHIFT, 0: learning-rate shift; delta = x >>> LR_SHIFT (arithmetic).

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin an operation; sampled only in IDLE
- train  in  1  captured with start; 1 = update weights on error
- target  in  1  captured with start; desired class (1 = positive)
- x_valid  in  1  input element valid
- x_data  in  DATA_WIDTH  signed input element
- x_ready  out  1  core accepts an element this cycle
- mem_wen  out  1  RAM write enable
- mem_ren  out  1  RAM read enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data; valid one cycle after mem_ren, 0 otherwise
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an operation completes
- y_out  out  1  last classification; held until the next SUM
- acc_out  out  ACC_WIDTH  last pre-activation sum; held
- updated  out  1  last operation wrote the RAM; held

Behaviour:
- Reset: state IDLE, element index 0. Registered outputs x_ready, mem_wen, mem_ren, busy, done, y_out and updated are 0. mem_addr, mem_wdata and acc_out are 0. x buffer contents are don't-care.
- Reset mid-operation returns to IDLE in one edge. No RAM access is issued afterwards. A weight whose write had not yet been issued keeps its old value.
- States: IDLE, FETCH, BIAS, SUM, UPD_RD, UPD_WR, DONE.
- IDLE:
  - start=1 captures train and target, clears acc and index, and moves to FETCH.
  - start while busy is ignored.
- FETCH:
  - x_ready=1.
  - On x_valid&&x_ready: store x into xbuf[i], drive mem_ren=1 and mem_addr=W_BASE+i, increment i.
  - The cycle after each issued read, acc += sext(mem_rdata*xbuf[i-1]). Full signed 2*DATA_WIDTH product, sign-extended.
  - x_valid gaps stall the fetch without losing products.
  - After element N_INPUTS-1 is accepted, go to BIAS.
- BIAS: x_ready=0. Issue the read of W_BASE+N_INPUTS and accumulate the final product.
- SUM:
  - acc += sext(bias). acc_out <= new sum; y_out <= (sum >= 0).
  - If train && y != target: updated <= 1, index <= 0, go to UPD_RD.
  - Otherwise updated <= 0, go to DONE.
- UPD_RD: mem_ren=1, addr=W_BASE+i. Index i runs 0..N_INPUTS, where i=N_INPUTS is the bias.
- UPD_WR:
  - mem_wen=1, same address.
  - wdata = sat(mem_rdata ± d), with + if target=1 and − if target=0.
  - d = xbuf[i]>>>LR_SHIFT for weights; d = 1 for the bias.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - After i=N_INPUTS go to DONE; else i++ and return to UPD_RD.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- mem_wen and mem_ren are never both 1 in the same cycle. Both are 0 outside FETCH, BIAS, UPD_RD and UPD_WR.
- Latency with x_valid held high and start accepted at edge T:
  - FETCH occupies T+1..T+N, BIAS T+N+1, SUM T+N+2.
  - done at T+N+3 with no update, or T+N+3+2(N+1) with an update.
- Accumulator arithmetic wraps modulo 2^ACC_WIDTH. This is unreachable with legal ACC_WIDTH.

Decomposition:
- Package sl_preceptron_pkg holds:
  - the state enum;
  - the saturating-add function;
  - localparam BIAS_ADDR = W_BASE+N_INPUTS;
  - the ACC_WIDTH legality check.
- Sub-module sl_preceptron_mac: signed multiply, sign-extend and accumulate register, with clear and enable inputs.
- FSM, x buffer and RAM port mux stay in sl_preceptron_core.

Test Plan:
- Inference, miss, no train:
  - Setup: N=16, all w=1, bias=-40, x=2 each, train=0, target=1.
  - Expected: acc_out=-8, y_out=0, updated=0, done at T+19, no mem_wen ever.
- Train on error:
  - Setup: same as above with train=1.
  - Expected: every w becomes 3, bias becomes -39, updated=1, done at T+53.
  - Rerun: acc_out=57, y_out=1, updated=0, RAM unchanged.
- Saturation:
  - Setup: w[0]=120, x[0]=20, target=1, forced error.
  - Expected: w[0]=127. With w[0]=-120, x[0]=20, target=0: w[0]=-128.
- Handshake stalls: x_valid toggled 1,0,0,1 pattern with random gaps. Expected: identical acc_out to the gap-free run; mem_ren pulses only on accepted beats.
- start while busy ignored: start pulsed in FETCH and in DONE. Expected: no restart, exactly one done per accepted start.
- Reset mid-update: rst asserted during UPD_WR of i=5. Expected: w[0..5] updated, w[6..15] and bias unchanged, busy=0 and done=0 next cycle, no further RAM access.
